// File: rtl/tmr_if.sv
// rtl/tmr_if.sv - SoC data bus bundle between a bus master and the tmr register file
//   din  : write data, master -> slave
//   addr : register address, master -> slave
//   we   : write enable (active-high), master -> slave
//   dout : registered read data, slave -> master
interface tmr_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;

    modport master (
        output din,
        output addr,
        output we,
        input  dout
    );

    modport slave (
        input  din,
        input  addr,
        input  we,
        output dout
    );
endinterface

// File: rtl/tmr.sv
// rtl/tmr.sv - 16-bit bus-mapped timer/counter with prescaler, compare match and overflow reload
//   clk     : clock
//   rst     : asynchronous active-high reset, clears all state
//   bus     : tmr_if.slave (din, addr, we in; dout registered read data out)
//   tmr_int : level interrupt request, (MF & MIE) | (OF & OIE), registered
//
//   addr 0 TCR  : [0] EN, [1] OS, [2] MIE, [3] OIE, [7:4] PS, [8] MF (W1C), [9] OF (W1C)
//   addr 1 TCNT : counter
//   addr 2 TCMP : compare value
//   addr 3 TRLD : reload value on overflow
module tmr #(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic clk,
    input  logic rst,
    tmr_if.slave bus,
    output logic tmr_int
);

    localparam logic [AW-1:0] A_TCR  = AW'(0);
    localparam logic [AW-1:0] A_TCNT = AW'(1);
    localparam logic [AW-1:0] A_TCMP = AW'(2);
    localparam logic [AW-1:0] A_TRLD = AW'(3);

    // control / status
    logic          en;
    logic          os;
    logic          mie;
    logic          oie;
    logic [3:0]    ps;
    logic          mf;
    logic          of_flg;

    // data registers
    logic [DW-1:0] tcnt;
    logic [DW-1:0] tcmp;
    logic [DW-1:0] trld;
    logic [14:0]   presc;

    // combinational helpers
    logic          wr_tcr;
    logic          wr_tcnt;
    logic          wr_tcmp;
    logic          wr_trld;
    logic          wr_stop;
    logic [14:0]   presc_term;
    logic          tick;
    logic          tick_eff;
    logic          wrap;
    logic [DW-1:0] cnt_new;
    logic          set_mf;
    logic          set_of;
    logic [DW-1:0] rd_data;

    always_comb begin
        wr_tcr  = bus.we && (bus.addr == A_TCR);
        wr_tcnt = bus.we && (bus.addr == A_TCNT);
        wr_tcmp = bus.we && (bus.addr == A_TCMP);
        wr_trld = bus.we && (bus.addr == A_TRLD);

        // A TCR write that clears EN overrides anything the counter would do this cycle.
        wr_stop = wr_tcr && !bus.din[0];

        // Terminal prescaler value 2^PS-1; PS=15 yields 0x7FFF, the full 15-bit range.
        presc_term = ~(15'h7FFF << ps);
        tick       = en && (presc == presc_term);

        // Bus writes to TCNT or a disabling TCR write discard the tick entirely,
        // including any flag it would have raised.
        tick_eff = tick && !wr_tcnt && !wr_stop;

        wrap    = (tcnt == {DW{1'b1}});
        cnt_new = wrap ? trld : (tcnt + DW'(1));

        set_of = tick_eff && wrap;
        // Compare against the value TCNT is about to take, so a reload equal to TCMP matches too.
        set_mf = tick_eff && (cnt_new == tcmp);

        rd_data = '0;
        case (bus.addr)
            A_TCR:   rd_data = {{(DW-10){1'b0}}, of_flg, mf, ps, oie, mie, os, en};
            A_TCNT:  rd_data = tcnt;
            A_TCMP:  rd_data = tcmp;
            A_TRLD:  rd_data = trld;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en      <= 1'b0;
            os      <= 1'b0;
            mie     <= 1'b0;
            oie     <= 1'b0;
            ps      <= 4'd0;
            mf      <= 1'b0;
            of_flg  <= 1'b0;
            tcnt    <= '0;
            tcmp    <= {DW{1'b1}};
            trld    <= '0;
            presc   <= 15'd0;
            bus.dout <= '0;
            tmr_int <= 1'b0;
        end else begin
            // Control bits: a TCR write always wins, including over a one-shot stop.
            if (wr_tcr) begin
                {ps, oie, mie, os, en} <= bus.din[7:0];
            end else if (set_of && os) begin
                en <= 1'b0;
            end

            // Hardware set takes priority over a simultaneous write-1-to-clear.
            mf     <= set_mf | (mf     & ~(wr_tcr & bus.din[8]));
            of_flg <= set_of | (of_flg & ~(wr_tcr & bus.din[9]));

            if (wr_tcnt) begin
                tcnt <= bus.din;
            end else if (tick_eff) begin
                tcnt <= cnt_new;
            end

            if (wr_tcmp) begin
                tcmp <= bus.din;
            end
            if (wr_trld) begin
                trld <= bus.din;
            end

            // Prescaler free-runs while enabled and is not reset by a PS change, so a
            // shrunken terminal value is reached only after wrapping through 0x7FFF.
            if (!en || wr_stop || tick) begin
                presc <= 15'd0;
            end else begin
                presc <= presc + 15'd1;
            end

            tmr_int <= (mf & mie) | (of_flg & oie);

            if (!bus.we) begin
                bus.dout <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_tmr.sv
// tb/tb_tmr.sv - directed self-checking bench for tmr
module tb_tmr;

    logic clk = 1'b0;
    logic rst;
    logic tmr_int;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tmr_if #(.DW(16), .AW(13)) bus ();

    tmr #(.DW(16), .AW(13)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .tmr_int (tmr_int)
    );

    task automatic wr(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b0;
        @(posedge clk);
        #1;
        d = bus.dout;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        logic [15:0] exp_rst [4];
        exp_rst = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        rst      = 1'b1;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.din  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", tmr_int); end
        checks++;
        if (bus.dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(13'(i), d);
            checks++;
            if (d !== exp_rst[i]) begin errors++; $display("FAIL reset_reg%0d got=%h exp=%h", i, d, exp_rst[i]); end
        end
        rd(13'h0004, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_4 got=%h exp=0000", d); end
        rd(13'h1002, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_1002 got=%h exp=0000", d); end
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL reset_int2 got=%b exp=0", tmr_int); end
    endtask

    task automatic test_match;
        logic [15:0] d;
        wr(13'd2, 16'h0005);
        wr(13'd1, 16'h0000);
        wr(13'd0, 16'h0005);
        // read at enabled edge k returns TCNT as it stood after edge k-1
        for (int k = 1; k <= 6; k++) begin
            rd(13'd1, d);
            checks++;
            if (d !== 16'(k - 1)) begin errors++; $display("FAIL match_tcnt%0d got=%h exp=%h", k, d, 16'(k - 1)); end
            checks++;
            if (tmr_int !== (k == 6)) begin errors++; $display("FAIL match_int%0d got=%b exp=%b", k, tmr_int, (k == 6)); end
        end
        rd(13'd0, d);
        checks++;
        if (d !== 16'h0105) begin errors++; $display("FAIL match_tcr got=%h exp=0105", d); end
        wr(13'd0, 16'h0105);
        idle(1);
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL match_clr_int got=%b exp=0", tmr_int); end
        rd(13'd0, d);
        checks++;
        if (d !== 16'h0005) begin errors++; $display("FAIL match_clr_tcr got=%h exp=0005", d); end
    endtask

    task automatic test_oneshot;
        logic [15:0] d;
        wr(13'd0, 16'h0300);
        wr(13'd2, 16'h0100);
        wr(13'd3, 16'h1234);
        wr(13'd1, 16'hFFFE);
        wr(13'd0, 16'h000B);
        rd(13'd1, d);
        checks++;
        if (d !== 16'hFFFE) begin errors++; $display("FAIL os_tcnt0 got=%h exp=fffe", d); end
        rd(13'd1, d);
        checks++;
        if (d !== 16'hFFFF) begin errors++; $display("FAIL os_tcnt1 got=%h exp=ffff", d); end
        rd(13'd1, d);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL os_reload got=%h exp=1234", d); end
        checks++;
        if (tmr_int !== 1'b1) begin errors++; $display("FAIL os_int got=%b exp=1", tmr_int); end
        idle(20);
        rd(13'd1, d);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL os_hold got=%h exp=1234", d); end
        rd(13'd0, d);
        checks++;
        if (d !== 16'h020A) begin errors++; $display("FAIL os_tcr got=%h exp=020a", d); end
        checks++;
        if (tmr_int !== 1'b1) begin errors++; $display("FAIL os_int_hold got=%b exp=1", tmr_int); end
    endtask

    task automatic test_prescale;
        logic [15:0] d;
        wr(13'd0, 16'h0300);
        wr(13'd1, 16'h0000);
        wr(13'd0, 16'h0031);
        idle(7);
        rd(13'd1, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL ps_edge7 got=%h exp=0000", d); end
        rd(13'd1, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL ps_edge8 got=%h exp=0001", d); end
        idle(71);
        rd(13'd1, d);
        checks++;
        if (d !== 16'h000A) begin errors++; $display("FAIL ps_80clk got=%h exp=000a", d); end
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL ps_int got=%b exp=0", tmr_int); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        wr(13'd0, 16'h0300);
        wr(13'd2, 16'h0007);
        wr(13'd1, 16'h0006);
        wr(13'd0, 16'h0001);
        // this edge also carries a tick that would have taken TCNT 6->7 and raised MF
        wr(13'd1, 16'h0007);
        rd(13'd1, d);
        checks++;
        if (d !== 16'h0007) begin errors++; $display("FAIL pri_tcnt got=%h exp=0007", d); end
        rd(13'd0, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL pri_nomf got=%h exp=0001", d); end
        wr(13'd1, 16'h0005);
        idle(1);
        // tick 6->7 matches TCMP on the same edge as the MF W1C
        wr(13'd0, 16'h0101);
        rd(13'd0, d);
        checks++;
        if (d !== 16'h0101) begin errors++; $display("FAIL pri_setwins got=%h exp=0101", d); end
    endtask

    task automatic test_async_reset;
        logic [15:0] d;
        logic [15:0] exp_rst [4];
        exp_rst = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        wr(13'd0, 16'h0300);
        wr(13'd2, 16'h0003);
        wr(13'd1, 16'h0000);
        wr(13'd0, 16'h0005);
        idle(5);
        rd(13'd2, d);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL ar_pre_dout got=%h exp=0003", d); end
        checks++;
        if (tmr_int !== 1'b1) begin errors++; $display("FAIL ar_pre_int got=%b exp=1", tmr_int); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL ar_int got=%b exp=0", tmr_int); end
        checks++;
        if (bus.dout !== 16'h0000) begin errors++; $display("FAIL ar_dout got=%h exp=0000", bus.dout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(13'(i), d);
            checks++;
            if (d !== exp_rst[i]) begin errors++; $display("FAIL ar_reg%0d got=%h exp=%h", i, d, exp_rst[i]); end
        end
        checks++;
        if (tmr_int !== 1'b0) begin errors++; $display("FAIL ar_int_after got=%b exp=0", tmr_int); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_oneshot();
        test_prescale();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr.md
Name: tmr

Overview:
- 16-bit bus-mapped timer/counter peripheral on the SoC data bus, same bus protocol as the interrupt controller.
- Drives one interrupt channel of the interrupt controller through tmr_int.
- tmr_int is active-high level, so that channel must be configured as high-level or rising-edge triggered.
- Provides a power-of-two prescaler, compare match, overflow with reload, and one-shot or auto-reload modes.

Parameters:
- DW, 16, data bus width.
- AW, 13, address bus width. Only addr values 0..3 decode.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Asynchronous, active-high. Clears all state.
- din  input  DW  bus write data.
- addr  input  AW  bus address.
- we  input  1  write enable, active-high.
- dout  output  DW  registered bus read data.
- tmr_int  output  1  interrupt request to the interrupt controller, active-high level.

Behaviour:
- Reset, applied asynchronously: TCR=0, TCNT=0, TCMP=0xFFFF, TRLD=0, prescaler=0, dout=0, tmr_int=0.
- Register map:
  - addr 0, TCR:
    - [0] EN: 1 = count.
    - [1] OS: 1 = one-shot, 0 = auto-reload.
    - [2] MIE: match interrupt enable.
    - [3] OIE: overflow interrupt enable.
    - [7:4] PS: prescale select.
    - [8] MF: match flag, write-1-to-clear.
    - [9] OF: overflow flag, write-1-to-clear.
    - [15:10] read as 0.
  - addr 1, TCNT: counter, read/write.
  - addr 2, TCMP: compare value.
  - addr 3, TRLD: reload value.
- Bus writes (we=1):
  - The addressed register updates at the clock edge.
  - A TCR write loads bits [7:0] directly. For din[8]/din[9]: 1 clears MF/OF, 0 leaves them unchanged.
  - dout holds its previous value during a write cycle.
- Bus reads (we=0):
  - dout is loaded at the edge with the addressed register, one-cycle latency.
  - Unmapped addresses return 0.
- Prescaler:
  - 15-bit counter, held at 0 while EN=0.
  - When EN=1 it increments every clk.
  - tick=1 when prescaler == 2^PS-1, then the prescaler wraps to 0.
  - PS=0 gives a tick every cycle. PS>15 cannot occur (4-bit field).
- On a tick:
  - If TCNT==0xFFFF: set OF, load TCNT<=TRLD. If OS=1, also clear EN (stop).
  - Otherwise TCNT<=TCNT+1.
  - If the new TCNT value equals TCMP, set MF. This includes the reload value equalling TCMP.
- Interrupt output:
  - tmr_int is registered: tmr_int <= (MF&MIE)|(OF&OIE).
  - It asserts one cycle after the flag edge and stays high until the flag is cleared or the enable bit is dropped.
- Priority and simultaneous events:
  - Flag set by hardware and W1C in the same cycle: the set wins, so the flag stays 1.
  - TCNT bus write and tick in the same cycle: the bus write wins. The tick is discarded and no MF/OF results from it.
  - TCR write with EN=0 in the same cycle as a tick: the write wins. The counter does not advance and the prescaler clears.
  - One-shot stop and a TCR write setting EN in the same cycle: the write wins, so EN=1.
- Changing PS while running does not reset the prescaler. The next tick occurs when the prescaler reaches the new terminal value. If the prescaler is already past the new terminal value, it counts to 0x7FFF, wraps, then ticks.
- Reset asserted mid-count: all state returns to reset values immediately. tmr_int drops without waiting for a clock edge.
- TCNT is not reset when EN goes 0. Counting resumes from the held value.

Test Plan:
1. Reset, then read addr 0..3 → dout = 0x0000, 0x0000, 0xFFFF, 0x0000, each one cycle after the read address; tmr_int=0.
2. TCMP=5, TCNT=0, TCR=0x0005 (EN, MIE, PS=0) → TCNT reaches 5 on the 5th enabled edge; MF=1 at that edge; tmr_int=1 one edge later; write TCR=0x0105 → MF=0 and tmr_int=0 on the following edge.
3. TCNT=0xFFFE, TRLD=0x1234, TCR=0x000B (EN, OS, OIE) → after 2 ticks: OF=1, TCNT=0x1234, EN=0; TCNT holds 0x1234 for a further 20 cycles; tmr_int=1.
4. PS=3, EN=1, TCNT=0 → TCNT increments exactly every 8 clk; after 80 clk TCNT=10.
5. Arrange a tick and a TCNT write of 0x0007 in the same cycle with TCMP=0x0007 → TCNT=7, MF stays 0. Then arrange a tick that sets MF in the same cycle as a W1C of MF → MF reads 1.
6. Assert rst asynchronously mid-count with tmr_int=1 → tmr_int and dout drop to 0 before the next clk edge; after release, all registers read their reset values.
